// File: rtl/pci_pkg.sv
// Shared definitions for the PCI bus-master initiator:
// PCI commands, AXI response codes and the FSM state type.
package pci_pkg;

    localparam logic [3:0] CMD_MEM_RD  = 4'b0110;
    localparam logic [3:0] CMD_MEM_WR  = 4'b0111;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_ADDR,
        ST_DATA,
        ST_EVAL,
        ST_GAP,
        ST_RESP
    } init_state_e;

endpackage

// File: rtl/pci_initiator_if.sv
// Single-beat AXI-lite request/response bundle between internal
// logic (master) and the PCI initiator (slave).
interface pci_initiator_if;

    logic        init_s_awvalid;
    logic        init_s_awready;
    logic [31:0] init_s_awaddr;
    logic        init_s_wvalid;
    logic        init_s_wready;
    logic [31:0] init_s_wdata;
    logic [3:0]  init_s_wstrb;
    logic        init_s_bvalid;
    logic        init_s_bready;
    logic [1:0]  init_s_bresp;
    logic        init_s_arvalid;
    logic        init_s_arready;
    logic [31:0] init_s_araddr;
    logic        init_s_rvalid;
    logic        init_s_rready;
    logic [31:0] init_s_rdata;
    logic [1:0]  init_s_rresp;

    modport master (
        output init_s_awvalid, init_s_awaddr,
        output init_s_wvalid, init_s_wdata, init_s_wstrb,
        output init_s_bready,
        output init_s_arvalid, init_s_araddr,
        output init_s_rready,
        input  init_s_awready, init_s_wready,
        input  init_s_bvalid, init_s_bresp,
        input  init_s_arready,
        input  init_s_rvalid, init_s_rdata, init_s_rresp
    );

    modport slave (
        input  init_s_awvalid, init_s_awaddr,
        input  init_s_wvalid, init_s_wdata, init_s_wstrb,
        input  init_s_bready,
        input  init_s_arvalid, init_s_araddr,
        input  init_s_rready,
        output init_s_awready, init_s_wready,
        output init_s_bvalid, init_s_bresp,
        output init_s_arready,
        output init_s_rvalid, init_s_rdata, init_s_rresp
    );

endinterface

// File: rtl/pci_initiator.sv
// AXI-lite to single-DWORD PCI memory bus-master bridge.
// Define INIT_RETRY_LIMIT_EN to fail with SLVERR after MAX_RETRY retries.
module pci_initiator
    import pci_pkg::*;
#(
    parameter int RETRY_GAP = 4,
    parameter int MAX_RETRY = 16
) (
    input  logic           CLK,
    input  logic           RST,
    pci_initiator_if.slave axi,
    output logic           REQUEST,
    output logic           REQUESTHOLD,
    output logic [3:0]     M_CBE,
    output logic           M_WRDN,
    output logic           COMPLETE,
    output logic           M_READY,
    output logic [31:0]    M_ADIO,
    output logic           M_ACTIVE,
    input  logic [31:0]    ADIO_OUT,
    input  logic           M_DATA_VLD,
    input  logic           M_SRC_EN,
    input  logic           TIME_OUT,
    input  logic           M_DATA,
    input  logic           M_ADDR_N,
    input  logic           STOPQ_N
);

    localparam int GW = $clog2(RETRY_GAP + 1);

    init_state_e   state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    wstrb_q, wstrb_d;
    logic          wr_q, wr_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    resp_q, resp_d;
    logic          xfer_q, xfer_d;
    logic          abort_q, abort_d;
    logic          seen_q, seen_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          retry_lim;
    logic          unused_ok;

`ifdef INIT_RETRY_LIMIT_EN
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [RW-1:0] retry_q, retry_d;

    assign retry_lim = (retry_q == RW'(MAX_RETRY));
    assign unused_ok = ^{M_SRC_EN, STOPQ_N};

    always_ff @(posedge CLK) begin
        if (RST) begin
            retry_q <= '0;
        end else begin
            retry_q <= retry_d;
        end
    end
`else
    assign retry_lim = 1'b0;
    assign unused_ok = ^{M_SRC_EN, STOPQ_N, MAX_RETRY == 0};
`endif

    assign REQUESTHOLD      = 1'b0;
    assign axi.init_s_bresp = resp_q;
    assign axi.init_s_rresp = resp_q;
    assign axi.init_s_rdata = rdata_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            wr_q    <= 1'b0;
            rdata_q <= '0;
            resp_q  <= RESP_OKAY;
            xfer_q  <= 1'b0;
            abort_q <= 1'b0;
            seen_q  <= 1'b0;
            gap_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            wr_q    <= wr_d;
            rdata_q <= rdata_d;
            resp_q  <= resp_d;
            xfer_q  <= xfer_d;
            abort_q <= abort_d;
            seen_q  <= seen_d;
            gap_q   <= gap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        wr_d    = wr_q;
        rdata_d = rdata_q;
        resp_d  = resp_q;
        xfer_d  = xfer_q;
        abort_d = abort_q;
        seen_d  = seen_q;
        gap_d   = gap_q;
`ifdef INIT_RETRY_LIMIT_EN
        retry_d = retry_q;
`endif
        axi.init_s_awready = 1'b0;
        axi.init_s_wready  = 1'b0;
        axi.init_s_arready = 1'b0;
        axi.init_s_bvalid  = 1'b0;
        axi.init_s_rvalid  = 1'b0;
        REQUEST  = 1'b0;
        M_CBE    = 4'b0000;
        M_WRDN   = 1'b0;
        COMPLETE = 1'b0;
        M_READY  = 1'b0;
        M_ADIO   = '0;
        M_ACTIVE = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Ready is gated by reset so no handshake is lost.
                if (!RST && axi.init_s_awvalid && axi.init_s_wvalid) begin
                    axi.init_s_awready = 1'b1;
                    axi.init_s_wready  = 1'b1;
                    addr_d  = axi.init_s_awaddr;
                    wdata_d = axi.init_s_wdata;
                    wstrb_d = axi.init_s_wstrb;
                    wr_d    = 1'b1;
                    state_d = ST_REQ;
`ifdef INIT_RETRY_LIMIT_EN
                    retry_d = '0;
`endif
                end else if (!RST && axi.init_s_arvalid) begin
                    axi.init_s_arready = 1'b1;
                    addr_d  = axi.init_s_araddr;
                    wdata_d = '0;
                    wstrb_d = '0;
                    wr_d    = 1'b0;
                    state_d = ST_REQ;
`ifdef INIT_RETRY_LIMIT_EN
                    retry_d = '0;
`endif
                end
            end
            ST_REQ: begin
                REQUEST  = 1'b1;
                M_ACTIVE = 1'b1;
                M_WRDN   = wr_q;
                xfer_d   = 1'b0;
                seen_d   = 1'b0;
                rdata_d  = '0;
                abort_d  = TIME_OUT;
                state_d  = TIME_OUT ? ST_EVAL : ST_WAIT_ADDR;
            end
            ST_WAIT_ADDR: begin
                M_ACTIVE = 1'b1;
                M_WRDN   = wr_q;
                M_ADIO   = addr_q & 32'hFFFF_FFFC;
                M_CBE    = wr_q ? CMD_MEM_WR : CMD_MEM_RD;
                if (TIME_OUT) begin
                    abort_d = 1'b1;
                    state_d = ST_EVAL;
                end else if (!M_ADDR_N) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                M_ACTIVE = 1'b1;
                M_WRDN   = wr_q;
                M_CBE    = wr_q ? ~wstrb_q : 4'b0000;
                M_ADIO   = wdata_q;
                M_READY  = 1'b1;
                COMPLETE = 1'b1;
                seen_d   = seen_q | M_DATA;
                if (M_DATA_VLD) begin
                    xfer_d = 1'b1;
                    if (!wr_q) rdata_d = ADIO_OUT;
                end
                if (TIME_OUT) abort_d = 1'b1;
                // A master abort may end without the core entering M_DATA.
                if (!M_DATA && (seen_q || abort_q)) state_d = ST_EVAL;
            end
            ST_EVAL: begin
                if (xfer_q) begin
                    resp_d  = RESP_OKAY;
                    state_d = ST_RESP;
                end else if (abort_q) begin
                    resp_d  = RESP_SLVERR;
                    state_d = ST_RESP;
                end else if (retry_lim) begin
                    resp_d  = RESP_SLVERR;
                    rdata_d = 32'hFFFF_FFFF;
                    state_d = ST_RESP;
                end else begin
                    gap_d   = '0;
                    state_d = ST_GAP;
`ifdef INIT_RETRY_LIMIT_EN
                    retry_d = retry_q + RW'(1);
`endif
                end
            end
            ST_GAP: begin
                if (gap_q == GW'(RETRY_GAP - 1)) begin
                    state_d = ST_REQ;
                end else begin
                    gap_d = gap_q + GW'(1);
                end
            end
            ST_RESP: begin
                axi.init_s_bvalid = wr_q;
                axi.init_s_rvalid = !wr_q;
                if (wr_q ? axi.init_s_bready : axi.init_s_rready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pci_initiator.sv
// Directed self-checking bench for pci_initiator with a scripted
// zero-wait PCI core; define INIT_RETRY_LIMIT_EN to add the limit test.
module tb_pci_initiator;

    localparam int RETRY_GAP = 4;
    localparam int MAX_RETRY = 16;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        REQUEST, REQUESTHOLD, M_WRDN, COMPLETE, M_READY, M_ACTIVE;
    logic [3:0]  M_CBE;
    logic [31:0] M_ADIO;
    logic [31:0] ADIO_OUT = '0;
    logic        M_DATA_VLD = 1'b0;
    logic        M_SRC_EN = 1'b0;
    logic        TIME_OUT = 1'b0;
    logic        M_DATA = 1'b0;
    logic        M_ADDR_N = 1'b1;
    logic        STOPQ_N = 1'b1;

    int n_cmp = 0;
    int n_fail = 0;
    int req_cnt = 0;
    int cyc = 0;

    pci_initiator_if axi();

    pci_initiator #(
        .RETRY_GAP(RETRY_GAP),
        .MAX_RETRY(MAX_RETRY)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .axi(axi),
        .REQUEST(REQUEST),
        .REQUESTHOLD(REQUESTHOLD),
        .M_CBE(M_CBE),
        .M_WRDN(M_WRDN),
        .COMPLETE(COMPLETE),
        .M_READY(M_READY),
        .M_ADIO(M_ADIO),
        .M_ACTIVE(M_ACTIVE),
        .ADIO_OUT(ADIO_OUT),
        .M_DATA_VLD(M_DATA_VLD),
        .M_SRC_EN(M_SRC_EN),
        .TIME_OUT(TIME_OUT),
        .M_DATA(M_DATA),
        .M_ADDR_N(M_ADDR_N),
        .STOPQ_N(STOPQ_N)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc++;
    always @(negedge CLK) if (REQUEST === 1'b1) req_cnt++;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic start_write(input logic [31:0] a, input logic [31:0] d,
                               input logic [3:0] s);
        axi.init_s_awaddr = a;
        axi.init_s_wdata = d;
        axi.init_s_wstrb = s;
        axi.init_s_awvalid = 1'b1;
        axi.init_s_wvalid = 1'b1;
        #1;
        n_cmp++;
        if ({axi.init_s_awready, axi.init_s_wready, axi.init_s_arready} !== 3'b110) begin
            n_fail++;
            $display("FAIL wr_accept: aw/w/ar ready=%b want 110",
                     {axi.init_s_awready, axi.init_s_wready, axi.init_s_arready});
        end
        @(negedge CLK);
        axi.init_s_awvalid = 1'b0;
        axi.init_s_wvalid = 1'b0;
    endtask

    task automatic start_read(input logic [31:0] a);
        axi.init_s_araddr = a;
        axi.init_s_arvalid = 1'b1;
        #1;
        n_cmp++;
        if ({axi.init_s_awready, axi.init_s_wready, axi.init_s_arready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rd_accept: aw/w/ar ready=%b want 001",
                     {axi.init_s_awready, axi.init_s_wready, axi.init_s_arready});
        end
        @(negedge CLK);
        axi.init_s_arvalid = 1'b0;
    endtask

    // Plays one bus attempt of the PCI core; returns at the EVAL cycle.
    task automatic run_core(input logic vld, input logic tout,
                            input logic [31:0] rd,
                            input logic [31:0] exp_a, input logic [3:0] exp_ca,
                            input logic [31:0] exp_d, input logic [31:0] dmask,
                            input logic [3:0] exp_cd, input logic exp_wr,
                            output int rcyc);
        int n = 0;
        while (REQUEST !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        rcyc = cyc;
        n_cmp++;
        if ({REQUEST, M_ACTIVE, M_WRDN} !== {2'b11, exp_wr}) begin
            n_fail++;
            $display("FAIL req_phase: REQUEST/M_ACTIVE/M_WRDN=%b want %b",
                     {REQUEST, M_ACTIVE, M_WRDN}, {2'b11, exp_wr});
        end
        @(negedge CLK);
        M_ADDR_N = 1'b0;
        #1;
        n_cmp++;
        if ({M_ADIO, M_CBE, REQUEST, M_WRDN} !== {exp_a, exp_ca, 1'b0, exp_wr}) begin
            n_fail++;
            $display("FAIL addr_phase: adio=%h cbe=%b req=%b wrdn=%b want %h %b 0 %b",
                     M_ADIO, M_CBE, REQUEST, M_WRDN, exp_a, exp_ca, exp_wr);
        end
        @(negedge CLK);
        M_ADDR_N = 1'b1;
        M_DATA = 1'b1;
        M_DATA_VLD = vld;
        TIME_OUT = tout;
        ADIO_OUT = rd;
        #1;
        n_cmp++;
        if ({M_ADIO & dmask, M_CBE, M_READY, COMPLETE, M_ACTIVE, REQUEST}
            !== {exp_d & dmask, exp_cd, 4'b1110}) begin
            n_fail++;
            $display("FAIL data_phase: adio=%h cbe=%b rdy/cmp/act/req=%b want %h %b 1110",
                     M_ADIO, M_CBE, {M_READY, COMPLETE, M_ACTIVE, REQUEST}, exp_d, exp_cd);
        end
        @(negedge CLK);
        M_DATA = 1'b0;
        M_DATA_VLD = 1'b0;
        TIME_OUT = 1'b0;
        ADIO_OUT = '0;
        @(negedge CLK);
        n_cmp++;
        if ({M_READY, COMPLETE, M_ACTIVE, REQUEST, axi.init_s_bvalid, axi.init_s_rvalid}
            !== 6'b0) begin
            n_fail++;
            $display("FAIL eval_quiet: rdy/cmp/act/req/bv/rv=%b want 000000",
                     {M_READY, COMPLETE, M_ACTIVE, REQUEST,
                      axi.init_s_bvalid, axi.init_s_rvalid});
        end
    endtask

    // Entered at the EVAL cycle: valid must show on the next cycle.
    task automatic wait_resp(input logic is_wr, input logic [1:0] exp_resp,
                             input logic [31:0] exp_rd, input logic [31:0] rmask,
                             input int hold);
        logic v;
        logic [1:0] r;
        @(negedge CLK);
        v = is_wr ? axi.init_s_bvalid : axi.init_s_rvalid;
        n_cmp++;
        if (v !== 1'b1) begin
            n_fail++;
            $display("FAIL resp_latency: valid=%b want 1", v);
        end
        repeat (hold) @(negedge CLK);
        v = is_wr ? axi.init_s_bvalid : axi.init_s_rvalid;
        r = is_wr ? axi.init_s_bresp : axi.init_s_rresp;
        n_cmp++;
        if ({v, r, axi.init_s_rdata & rmask} !== {1'b1, exp_resp, exp_rd & rmask}) begin
            n_fail++;
            $display("FAIL resp_value: valid=%b resp=%b rdata=%h want 1 %b %h",
                     v, r, axi.init_s_rdata, exp_resp, exp_rd);
        end
        if (is_wr) axi.init_s_bready = 1'b1;
        else axi.init_s_rready = 1'b1;
        @(negedge CLK);
        axi.init_s_bready = 1'b0;
        axi.init_s_rready = 1'b0;
        n_cmp++;
        if ({axi.init_s_bvalid, axi.init_s_rvalid} !== 2'b00) begin
            n_fail++;
            $display("FAIL resp_release: bvalid/rvalid=%b want 00",
                     {axi.init_s_bvalid, axi.init_s_rvalid});
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        axi.init_s_awvalid = 1'b1;
        axi.init_s_wvalid = 1'b1;
        axi.init_s_arvalid = 1'b1;
        repeat (3) @(negedge CLK);
        n_cmp++;
        if ({axi.init_s_awready, axi.init_s_wready, axi.init_s_arready, REQUEST,
             REQUESTHOLD, M_WRDN, COMPLETE, M_READY, M_ACTIVE,
             axi.init_s_bvalid, axi.init_s_rvalid} !== 11'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: control outputs not all zero");
        end
        n_cmp++;
        if ({M_CBE, M_ADIO, axi.init_s_rdata, axi.init_s_bresp, axi.init_s_rresp}
            !== 72'b0) begin
            n_fail++;
            $display("FAIL reset_data: cbe=%b adio=%h rdata=%h want 0",
                     M_CBE, M_ADIO, axi.init_s_rdata);
        end
        axi.init_s_awvalid = 1'b0;
        axi.init_s_wvalid = 1'b0;
        axi.init_s_arvalid = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_write();
        int r0, rc;
        r0 = req_cnt;
        start_write(32'h1000_0004, 32'hDEAD_BEEF, 4'b0011);
        run_core(1'b1, 1'b0, 32'h0, 32'h1000_0004, 4'b0111,
                 32'hDEAD_BEEF, 32'hFFFF_FFFF, 4'b1100, 1'b1, rc);
        wait_resp(1'b1, 2'b00, 32'h0, 32'h0, 0);
        n_cmp++;
        if (req_cnt - r0 !== 1) begin
            n_fail++;
            $display("FAIL write_req_count: %0d want 1", req_cnt - r0);
        end
    endtask

    task automatic test_read();
        int rc;
        start_read(32'h2000_0000);
        run_core(1'b1, 1'b0, 32'h1234_5678, 32'h2000_0000, 4'b0110,
                 32'h0, 32'h0, 4'b0000, 1'b0, rc);
        wait_resp(1'b0, 2'b00, 32'h1234_5678, 32'hFFFF_FFFF, 2);
    endtask

    task automatic test_retry();
        int r0, rc1, rc2, rc3;
        r0 = req_cnt;
        start_write(32'h4000_0010, 32'hCAFE_F00D, 4'b1111);
        run_core(1'b0, 1'b0, 32'h0, 32'h4000_0010, 4'b0111,
                 32'hCAFE_F00D, 32'hFFFF_FFFF, 4'b0000, 1'b1, rc1);
        run_core(1'b0, 1'b0, 32'h0, 32'h4000_0010, 4'b0111,
                 32'hCAFE_F00D, 32'hFFFF_FFFF, 4'b0000, 1'b1, rc2);
        run_core(1'b1, 1'b0, 32'h0, 32'h4000_0010, 4'b0111,
                 32'hCAFE_F00D, 32'hFFFF_FFFF, 4'b0000, 1'b1, rc3);
        wait_resp(1'b1, 2'b00, 32'h0, 32'h0, 0);
        n_cmp++;
        if (rc2 - rc1 - 1 < RETRY_GAP || rc3 - rc2 - 1 < RETRY_GAP) begin
            n_fail++;
            $display("FAIL retry_gap: idle %0d/%0d want >= %0d",
                     rc2 - rc1 - 1, rc3 - rc2 - 1, RETRY_GAP);
        end
        n_cmp++;
        if (req_cnt - r0 !== 3) begin
            n_fail++;
            $display("FAIL retry_req_count: %0d want 3", req_cnt - r0);
        end
    endtask

    task automatic test_timeout();
        int r0, rc;
        start_read(32'h5000_0000);
        run_core(1'b0, 1'b1, 32'h0, 32'h5000_0000, 4'b0110,
                 32'h0, 32'h0, 4'b0000, 1'b0, rc);
        wait_resp(1'b0, 2'b10, 32'h0, 32'h0, 0);
        r0 = req_cnt;
        repeat (20) @(negedge CLK);
        n_cmp++;
        if (req_cnt !== r0) begin
            n_fail++;
            $display("FAIL timeout_no_retry: %0d extra REQUEST pulses", req_cnt - r0);
        end
    endtask

    task automatic test_back_to_back();
        int rc;
        axi.init_s_araddr = 32'h6000_0008;
        axi.init_s_arvalid = 1'b1;
        start_write(32'h3000_0007, 32'h0BAD_F00D, 4'b1010);
        n_cmp++;
        if (axi.init_s_arready !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_read_held: arready=%b want 0", axi.init_s_arready);
        end
        run_core(1'b1, 1'b0, 32'h0, 32'h3000_0004, 4'b0111,
                 32'h0BAD_F00D, 32'hFFFF_FFFF, 4'b0101, 1'b1, rc);
        wait_resp(1'b1, 2'b00, 32'h0, 32'h0, 1);
        n_cmp++;
        if (axi.init_s_arready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_read_accept: arready=%b want 1", axi.init_s_arready);
        end
        @(negedge CLK);
        axi.init_s_arvalid = 1'b0;
        run_core(1'b1, 1'b0, 32'hA5A5_5A5A, 32'h6000_0008, 4'b0110,
                 32'h0, 32'h0, 4'b0000, 1'b0, rc);
        wait_resp(1'b0, 2'b00, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 0);
    endtask

    task automatic test_reset_mid();
        int n = 0;
        int seen_b = 0;
        int rc;
        start_write(32'h7000_0000, 32'h1111_2222, 4'b1111);
        while (REQUEST !== 1'b1 && n < 60) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        M_ADDR_N = 1'b0;
        @(negedge CLK);
        M_ADDR_N = 1'b1;
        M_DATA = 1'b1;
        #1;
        n_cmp++;
        if ({M_READY, COMPLETE} !== 2'b11) begin
            n_fail++;
            $display("FAIL rst_mid_in_data: rdy/cmp=%b want 11", {M_READY, COMPLETE});
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        M_DATA = 1'b0;
        n_cmp++;
        if ({REQUEST, COMPLETE, M_READY, M_ACTIVE, axi.init_s_bvalid} !== 5'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outputs: req/cmp/rdy/act/bv=%b want 00000",
                     {REQUEST, COMPLETE, M_READY, M_ACTIVE, axi.init_s_bvalid});
        end
        repeat (6) begin
            @(negedge CLK);
            if (axi.init_s_bvalid === 1'b1 || REQUEST === 1'b1) seen_b++;
        end
        n_cmp++;
        if (seen_b !== 0) begin
            n_fail++;
            $display("FAIL rst_mid_discard: %0d activity cycles want 0", seen_b);
        end
        start_write(32'h7000_0004, 32'h3333_4444, 4'b0001);
        run_core(1'b1, 1'b0, 32'h0, 32'h7000_0004, 4'b0111,
                 32'h3333_4444, 32'hFFFF_FFFF, 4'b1110, 1'b1, rc);
        wait_resp(1'b1, 2'b00, 32'h0, 32'h0, 0);
    endtask

`ifdef INIT_RETRY_LIMIT_EN
    task automatic test_retry_limit();
        int r0, rc;
        r0 = req_cnt;
        start_read(32'h8000_0000);
        for (int i = 0; i <= MAX_RETRY; i++) begin
            run_core(1'b0, 1'b0, 32'h0, 32'h8000_0000, 4'b0110,
                     32'h0, 32'h0, 4'b0000, 1'b0, rc);
        end
        wait_resp(1'b0, 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        n_cmp++;
        if (req_cnt - r0 !== MAX_RETRY + 1) begin
            n_fail++;
            $display("FAIL retry_limit_count: %0d want %0d",
                     req_cnt - r0, MAX_RETRY + 1);
        end
    endtask
`endif

    initial begin
        axi.init_s_awvalid = 1'b0;
        axi.init_s_awaddr = '0;
        axi.init_s_wvalid = 1'b0;
        axi.init_s_wdata = '0;
        axi.init_s_wstrb = '0;
        axi.init_s_bready = 1'b0;
        axi.init_s_arvalid = 1'b0;
        axi.init_s_araddr = '0;
        axi.init_s_rready = 1'b0;
        @(negedge CLK);
        test_reset();
        test_write();
        test_read();
        test_retry();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
`ifdef INIT_RETRY_LIMIT_EN
        test_retry_limit();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
